// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl
// Purpose  : Sequences NUM_PROGS processor runs (Start pulse, Ack wait),
//            measures each run in cycles and aborts on a per-program watchdog.
//            Define RUN_CTRL_TOTAL_EN to build the TotalCount accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module run_ctrl #(
    parameter int unsigned NUM_PROGS = 3,
    parameter int unsigned CW        = 16,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned TIMEOUT   = 16'hFFFF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Ack,
    output logic          Start,
    output logic [7:0]    ProgIdx,
    output logic [CW-1:0] CycleCount,
    output logic          CountValid,
    output logic          Busy,
    output logic          Done,
    output logic          Timeout,
    output logic [CW+7:0] TotalCount
);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_start    = 3'd1;
    localparam logic [2:0] c_wait_low = 3'd2;
    localparam logic [2:0] c_run      = 3'd3;
    localparam logic [2:0] c_report   = 3'd4;
    localparam logic [2:0] c_done     = 3'd5;

    localparam int              c_sw         = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [c_sw-1:0] c_start_last = c_sw'(START_CYC - 1);
    localparam logic [CW-1:0]   c_wd_last    = CW'(TIMEOUT - 1);
    localparam logic [7:0]      c_last_prog  = 8'(NUM_PROGS - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [c_sw-1:0] r_start_cnt;
    logic [CW-1:0]   r_cyc_cnt;
    logic [CW-1:0]   r_wd_cnt;
    logic [CW-1:0]   w_cyc_inc;
    logic [CW-1:0]   w_cyc_next;
    logic            w_in_wait;
    logic            w_expire;
    logic            w_report_load;
    logic            w_go;

    assign w_in_wait     = (r_state == c_wait_low) || (r_state == c_run);
    assign w_expire      = w_in_wait && (r_wd_cnt == c_wd_last);
    assign w_report_load = (r_state == c_run) && Ack && !w_expire;
    assign w_go          = ((r_state == c_idle) || (r_state == c_done)) && Go;
    assign w_cyc_inc     = (r_cyc_cnt == '1) ? r_cyc_cnt : r_cyc_cnt + CW'(1);
    assign w_cyc_next    = Ack ? r_cyc_cnt : w_cyc_inc;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the watchdog takes priority over a coincident Ack
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle, c_done: begin
                if (Go) w_next_state = c_start;
            end
            c_start: begin
                if (r_start_cnt == c_start_last) w_next_state = c_wait_low;
            end
            c_wait_low: begin
                if (w_expire)  w_next_state = c_done;
                else if (!Ack) w_next_state = c_run;
            end
            c_run: begin
                if (w_expire) w_next_state = c_done;
                else if (Ack) w_next_state = c_report;
            end
            c_report: begin
                if (ProgIdx == c_last_prog) w_next_state = c_done;
                else                        w_next_state = c_start;
            end
            default: w_next_state = c_idle;
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        Start = 1'b0;
        Busy  = 1'b1;
        Done  = 1'b0;
        case (r_state)
            c_idle:  Busy = 1'b0;
            c_start: Start = 1'b1;
            c_done: begin
                Busy = 1'b0;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_start_cnt <= '0;
            r_cyc_cnt   <= '0;
            r_wd_cnt    <= '0;
        end else begin
            if ((r_state == c_start) && (w_next_state == c_start)) begin
                r_start_cnt <= r_start_cnt + c_sw'(1);
            end else begin
                r_start_cnt <= '0;
            end

            if (r_state == c_start) begin
                r_cyc_cnt <= '0;
                r_wd_cnt  <= '0;
            end else if (w_in_wait) begin
                r_cyc_cnt <= w_cyc_next;
                r_wd_cnt  <= r_wd_cnt + CW'(1);
            end
        end
    end

    // Result reporting and sequence bookkeeping
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ProgIdx    <= '0;
            CycleCount <= '0;
            CountValid <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            CountValid <= 1'b0;
            if (w_go) begin
                ProgIdx <= '0;
                Timeout <= 1'b0;
            end
            if (w_expire) begin
                CycleCount <= w_cyc_next;
                CountValid <= 1'b1;
                Timeout    <= 1'b1;
            end else if (w_report_load) begin
                CycleCount <= r_cyc_cnt;
                CountValid <= 1'b1;
            end
            if ((r_state == c_report) && (ProgIdx != c_last_prog)) begin
                ProgIdx <= ProgIdx + 8'd1;
            end
        end
    end

`ifdef RUN_CTRL_TOTAL_EN
    logic [CW+7:0] r_total;
    logic [CW+8:0] w_total_sum;

    assign w_total_sum = {1'b0, r_total} + (CW+9)'(r_cyc_cnt);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_total <= '0;
        end else if (w_go) begin
            r_total <= '0;
        end else if (w_report_load) begin
            r_total <= w_total_sum[CW+8] ? '1 : w_total_sum[CW+7:0];
        end
    end

    assign TotalCount = r_total;
`else
    assign TotalCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// Directed bench for run_ctrl: program sequencing, stale Ack, watchdog,
// ignored Go and asynchronous reset mid-run.
module tb_run_ctrl;

    localparam int CW = 16;
`ifdef RUN_CTRL_TOTAL_EN
    localparam bit TOT_EN = 1'b1;
`else
    localparam bit TOT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic          ack;
    logic          start;
    logic [7:0]    prog_idx;
    logic [CW-1:0] cycle_count;
    logic          count_valid;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW+7:0] total_count;

    int checks = 0;
    int errors = 0;

    run_ctrl #(
        .NUM_PROGS(3),
        .CW(CW),
        .START_CYC(2),
        .TIMEOUT(20)
    ) dut (
        .Clk(clk),
        .Reset(reset),
        .Go(go),
        .Ack(ack),
        .Start(start),
        .ProgIdx(prog_idx),
        .CycleCount(cycle_count),
        .CountValid(count_valid),
        .Busy(busy),
        .Done(done),
        .Timeout(timeout),
        .TotalCount(total_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge that put the DUT in START; leaves it in REPORT
    task automatic do_prog(input int k, input int stale, input logic [7:0] idx);
        ack = 1'b1;
        checks++;
        if (start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_c1 p%0d: start=%b busy=%b expected 1 1", idx, start, busy);
        end
        tick();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL start_c2 p%0d: start=%b expected 1", idx, start);
        end
        tick();
        checks++;
        if (start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_fall p%0d: start=%b busy=%b expected 0 1", idx, start, busy);
        end
        for (int i = 0; i < stale; i++) begin
            tick();
            checks++;
            if (start !== 1'b0 || count_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_low p%0d: start=%b valid=%b busy=%b expected 0 0 1",
                         idx, start, count_valid, busy);
            end
        end
        ack = 1'b0;
        repeat (k) tick();
        ack = 1'b1;
        tick();
        checks++;
        if (count_valid !== 1'b1 || cycle_count !== CW'(k) || prog_idx !== idx || start !== 1'b0) begin
            errors++;
            $display("FAIL report p%0d: valid=%b count=%0d idx=%0d start=%b expected 1 %0d %0d 0",
                     idx, count_valid, cycle_count, prog_idx, start, k, idx);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go    = 1'b0;
        ack   = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count_valid !== 1'b0 ||
                timeout !== 1'b0 || prog_idx !== 8'd0 || cycle_count !== '0 || total_count !== '0) begin
                errors++;
                $display("FAIL reset_idle c%0d: start=%b busy=%b done=%b valid=%b to=%b idx=%0d cnt=%0d tot=%0d expected all 0",
                         i, start, busy, done, count_valid, timeout, prog_idx, cycle_count, total_count);
            end
        end
    endtask

    task automatic test_sequence();
        go = 1'b1;
        tick();
        go = 1'b0;
        do_prog(5, 0, 8'd0);
        tick();
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse: valid=%b expected 0", count_valid);
        end
        do_prog(9, 0, 8'd1);
        tick();
        do_prog(2, 0, 8'd2);
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count_valid !== 1'b0 || timeout !== 1'b0 ||
            total_count !== (TOT_EN ? 24'd16 : 24'd0)) begin
            errors++;
            $display("FAIL seq_done: done=%b busy=%b valid=%b to=%b tot=%0d expected 1 0 0 0 %0d",
                     done, busy, count_valid, timeout, total_count, TOT_EN ? 16 : 0);
        end
        repeat (3) tick();
        checks++;
        if (done !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%b start=%b expected 1 0", done, start);
        end
    endtask

    task automatic test_stale_ack();
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (prog_idx !== 8'd0 || done !== 1'b0 || total_count !== '0) begin
            errors++;
            $display("FAIL restart: idx=%0d done=%b tot=%0d expected 0 0 0", prog_idx, done, total_count);
        end
        do_prog(4, 3, 8'd0);
        tick();
        do_prog(1, 0, 8'd1);
        tick();
        do_prog(1, 0, 8'd2);
        tick();
        checks++;
        if (done !== 1'b1 || total_count !== (TOT_EN ? 24'd6 : 24'd0)) begin
            errors++;
            $display("FAIL stale_done: done=%b tot=%0d expected 1 %0d", done, total_count, TOT_EN ? 6 : 0);
        end
    endtask

    task automatic test_timeout();
        go = 1'b1;
        tick();
        go = 1'b0;
        do_prog(3, 0, 8'd0);
        tick();
        checks++;
        if (start !== 1'b1 || prog_idx !== 8'd1) begin
            errors++;
            $display("FAIL to_p1_start: start=%b idx=%0d expected 1 1", start, prog_idx);
        end
        tick();
        tick();
        ack = 1'b0;
        repeat (19) tick();
        checks++;
        if (timeout !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early: to=%b done=%b busy=%b expected 0 0 1", timeout, done, busy);
        end
        tick();
        checks++;
        if (timeout !== 1'b1 || done !== 1'b1 || count_valid !== 1'b1 || cycle_count !== 16'd20 ||
            prog_idx !== 8'd1 || total_count !== (TOT_EN ? 24'd3 : 24'd0)) begin
            errors++;
            $display("FAIL to_expire: to=%b done=%b valid=%b cnt=%0d idx=%0d tot=%0d expected 1 1 1 20 1 %0d",
                     timeout, done, count_valid, cycle_count, prog_idx, total_count, TOT_EN ? 3 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (start !== 1'b0 || count_valid !== 1'b0 || timeout !== 1'b1 || done !== 1'b1 || prog_idx !== 8'd1) begin
                errors++;
                $display("FAIL to_hold c%0d: start=%b valid=%b to=%b done=%b idx=%0d expected 0 0 1 1 1",
                         i, start, count_valid, timeout, done, prog_idx);
            end
        end
        ack = 1'b1;
    endtask

    task automatic test_go_ignored();
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (timeout !== 1'b0 || prog_idx !== 8'd0 || start !== 1'b1) begin
            errors++;
            $display("FAIL go_in_done: to=%b idx=%0d start=%b expected 0 0 1", timeout, prog_idx, start);
        end
        tick();
        tick();
        ack = 1'b0;
        tick();
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (start !== 1'b0 || busy !== 1'b1 || count_valid !== 1'b0) begin
            errors++;
            $display("FAIL go_in_run: start=%b busy=%b valid=%b expected 0 1 0", start, busy, count_valid);
        end
        repeat (3) tick();
        ack = 1'b1;
        tick();
        checks++;
        if (count_valid !== 1'b1 || cycle_count !== 16'd6 || prog_idx !== 8'd0) begin
            errors++;
            $display("FAIL go_run_report: valid=%b cnt=%0d idx=%0d expected 1 6 0", count_valid, cycle_count, prog_idx);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        tick();
        tick();
        ack = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count_valid !== 1'b0 || timeout !== 1'b0 ||
            prog_idx !== 8'd0 || cycle_count !== '0 || total_count !== '0) begin
            errors++;
            $display("FAIL async_reset: start=%b busy=%b done=%b valid=%b to=%b idx=%0d cnt=%0d tot=%0d expected all 0",
                     start, busy, done, count_valid, timeout, prog_idx, cycle_count, total_count);
        end
        ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold c%0d: valid=%b busy=%b expected 0 0", i, count_valid, busy);
            end
        end
        reset = 1'b0;
        go    = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (prog_idx !== 8'd0 || start !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: idx=%0d start=%b expected 0 1", prog_idx, start);
        end
        do_prog(2, 0, 8'd0);
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stale_ack();
        test_timeout();
        test_go_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
